pipe_stage_reg: RTL and testbench

- Generic elastic pipeline register that supersedes the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary packed payload with a valid/ready handshake, optional 2-entry skid buffering, flush, and a parameterised bubble value.
- The bubble value matters for fields whose "idle" encoding is nonzero, e.g. MemtoReg=1 on a bubble.
- Each stage instantiates it with the stage's concatenated control and data bus.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_slot_reg.sv | 31 +++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encoding plus
// per-stage payload widths and bubble encodings.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

  localparam int IF_ID_W = 64;
  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = '0;

  // MemtoReg idles high so a bubble never selects the ALU path
  localparam int ID_EX_W   = 128;
  localparam int ID_EX_M2R = 3;
  localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE =
    ID_EX_W'(1) << ID_EX_M2R;

  localparam int EX_MEM_W   = 112;
  localparam int EX_MEM_M2R = 2;
  localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE =
    EX_MEM_W'(1) << EX_MEM_M2R;

  localparam int MEM_WB_W   = 72;
  localparam int MEM_WB_M2R = 1;
  localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE =
    MEM_WB_W'(1) << MEM_WB_M2R;

endpackage

// File: rtl/pipe_slot_reg.sv
// One payload slot: load, clear-to-bubble, or hold.
// Clear wins over load.
module pipe_slot_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr)       q_d = BUBBLE_VAL;
    else if (load) q_d = d;
  end

  always_ff @(negedge clk) begin
    if (rst) q_q <= BUBBLE_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready, flush,
// bubble value and optional two-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_t              occ_q, occ_d;
  logic              acc, cons;
  logic              main_ld, main_clr;
  logic              skid_ld, skid_clr;
  logic [DATA_W-1:0] main_d, main_q, skid_q;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign acc       = in_valid & in_ready;
  assign cons      = out_valid & out_ready;

  if (SKID) begin : g_rdy_reg
    assign in_ready = (occ_q != OCC_TWO);
  end else begin : g_rdy_comb
    assign in_ready = !out_valid | out_ready;
  end

  always_comb begin
    occ_d    = occ_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    main_d   = in_data;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (acc) begin
          occ_d   = OCC_ONE;
          main_ld = 1'b1;
        end
      end
      OCC_ONE: begin
        if (acc && cons) begin
          main_ld = 1'b1;
        end else if (acc && SKID) begin
          occ_d   = OCC_TWO;
          skid_ld = 1'b1;
        end else if (cons) begin
          occ_d    = OCC_EMPTY;
          main_clr = 1'b1;
        end
      end
      OCC_TWO: begin
        if (cons) begin
          occ_d    = OCC_ONE;
          main_ld  = 1'b1;
          main_d   = skid_q;
          skid_clr = 1'b1;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // a consume still completes downstream; only held state dies
    if (flush) begin
      occ_d    = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) occ_q <= OCC_EMPTY;
    else     occ_q <= occ_d;
  end

  pipe_slot_reg #(
    .DATA_W    (DATA_W),
    .BUBBLE_VAL(BUBBLE_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .load(main_ld),
    .clr (main_clr),
    .d   (main_d),
    .q   (main_q)
  );

  if (SKID) begin : g_skid
    pipe_slot_reg #(
      .DATA_W    (DATA_W),
      .BUBBLE_VAL(BUBBLE_VAL)
    ) u_skid (
      .clk (clk),
      .rst (rst),
      .load(skid_ld),
      .clr (skid_clr),
      .d   (in_data),
      .q   (skid_q)
    );
  end else begin : g_noskid
    assign skid_q = BUBBLE_VAL;
  end

  a_in_stable: assert property (
    @(negedge clk) disable iff (rst)
    (in_valid && !in_ready && !flush) |=> $stable(in_data));

  a_occ_range: assert property (
    @(negedge clk) disable iff (rst)
    occ_q != 2'd3);

  a_occ_noskid: assert property (
    @(negedge clk) disable iff (rst)
    SKID || (occ_q != OCC_TWO));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances
// compared against a queue-based reference model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], flush[2], in_valid[2], out_ready[2];
  logic       in_ready[2], out_valid[2];
  logic [7:0] in_data[2], out_data[2];
  logic [1:0] occ[2];

  int checks = 0;
  int errors = 0;

  logic [7:0] m0[$];
  logic [7:0] m1[$];

  pipe_stage_reg #(
    .DATA_W(8), .BUBBLE_VAL(8'hA5), .SKID(1'b0)
  ) u_s0 (
    .clk(clk), .rst(rst[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(
    .DATA_W(8), .BUBBLE_VAL(8'hA5), .SKID(1'b1)
  ) u_s1 (
    .clk(clk), .rst(rst[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occ[1])
  );

  function automatic int msize(int k);
    return (k == 1) ? m1.size() : m0.size();
  endfunction

  function automatic logic [7:0] mhead(int k);
    if (msize(k) == 0) return 8'hA5;
    return (k == 1) ? m1[0] : m0[0];
  endfunction

  function automatic logic mready(int k);
    if (k == 1) return msize(1) != 2;
    return (msize(0) == 0) || out_ready[0];
  endfunction

  task automatic mstep(int k);
    logic acc, cons;
    acc  = in_valid[k] && mready(k);
    cons = (msize(k) > 0) && out_ready[k];
    if (rst[k] || flush[k]) begin
      if (k == 1) m1.delete(); else m0.delete();
    end else begin
      if (cons) begin
        if (k == 1) void'(m1.pop_front());
        else        void'(m0.pop_front());
      end
      if (acc) begin
        if (k == 1) m1.push_back(in_data[k]);
        else        m0.push_back(in_data[k]);
      end
    end
  endtask

  task automatic adv();
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 0; flush[k] = 0;
      in_valid[k] = 0; out_ready[k] = 0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; flush[k] = 1; in_valid[k] = 1;
      in_data[k] = 8'($urandom); out_ready[k] = 1;
    end
    repeat (2) begin
      adv();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (out_valid[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_vld%0d: got %b want 0", k, out_valid[k]);
        end
        checks++;
        if (out_data[k] !== 8'hA5) begin
          errors++;
          $display("FAIL reset_data%0d: got %h want a5", k, out_data[k]);
        end
        checks++;
        if (occ[k] !== 2'd0) begin
          errors++;
          $display("FAIL reset_occ%0d: got %0d want 0", k, occ[k]);
        end
        checks++;
        if (in_ready[k] !== 1'b1) begin
          errors++;
          $display("FAIL reset_rdy%0d: got %b want 1", k, in_ready[k]);
        end
      end
    end
    idle();
  endtask

  task automatic test_stream();
    out_ready[1] = 1;
    for (int i = 1; i <= 18; i++) begin
      in_valid[1] = (i <= 16);
      in_data[1]  = 8'(i);
      #1;
      checks++;
      if (out_data[1] !== mhead(1) || occ[1] !== 2'(msize(1))) begin
        errors++;
        $display("FAIL stream_model: got %h/%0d want %h/%0d",
                 out_data[1], occ[1], mhead(1), msize(1));
      end
      if (i >= 2 && i <= 17) begin
        checks++;
        if (out_data[1] !== 8'(i - 1) || out_valid[1] !== 1'b1
            || occ[1] !== 2'd1) begin
          errors++;
          $display("FAIL stream_seq: got %h/%b/%0d want %h/1/1",
                   out_data[1], out_valid[1], occ[1], 8'(i - 1));
        end
      end
      adv();
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [7:0] src[$];
    logic [7:0] got[$];
    src = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < 10; c++) begin
      out_ready[1] = (c >= 5);
      in_valid[1]  = (src.size() > 0);
      if (src.size() > 0) in_data[1] = src[0];
      #1;
      checks++;
      if (occ[1] !== 2'(msize(1)) || in_ready[1] !== mready(1)
          || out_data[1] !== mhead(1)) begin
        errors++;
        $display("FAIL bp_model c%0d: got %0d/%b/%h want %0d/%b/%h",
                 c, occ[1], in_ready[1], out_data[1],
                 msize(1), mready(1), mhead(1));
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (occ[1] !== 2'(c) || in_ready[1] !== (c == 1)) begin
          errors++;
          $display("FAIL bp_fill c%0d: got %0d/%b want %0d/%b",
                   c, occ[1], in_ready[1], c, (c == 1));
        end
      end
      if (out_valid[1] && out_ready[1]) got.push_back(out_data[1]);
      if (in_valid[1] && mready(1)) void'(src.pop_front());
      adv();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 8'(8'h11 * (i + 1))) begin
          errors++;
          $display("FAIL bp_order%0d: got %h want %h",
                   i, got[i], 8'(8'h11 * (i + 1)));
        end
      end
    end
    idle();
  endtask

  task automatic test_flush_full();
    in_valid[1] = 1; in_data[1] = 8'hAA; adv();
    in_data[1] = 8'hBB; adv();
    flush[1] = 1; in_data[1] = 8'h44;
    #1;
    checks++;
    if (occ[1] !== 2'd2) begin
      errors++;
      $display("FAIL flush_pre: got %0d want 2", occ[1]);
    end
    adv();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (occ[1] !== 2'd0 || out_valid[1] !== 1'b0
          || out_data[1] !== 8'hA5) begin
        errors++;
        $display("FAIL flush_post%0d: got %0d/%b/%h want 0/0/a5",
                 i, occ[1], out_valid[1], out_data[1]);
      end
      out_ready[1] = 1;
      adv();
    end
    idle();
  endtask

  task automatic test_skid0_stall();
    in_valid[0] = 1; in_data[0] = 8'h60; adv();
    in_data[0] = 8'h61;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || occ[0] !== 2'd1) begin
      errors++;
      $display("FAIL s0_stall: got %b/%0d want 0/1",
               in_ready[0], occ[0]);
    end
    adv();
    out_ready[0] = 1;
    for (int i = 0; i < 4; i++) begin
      in_data[0] = 8'(8'h61 + i);
      #1;
      checks++;
      if (in_ready[0] !== 1'b1 || occ[0] !== 2'd1
          || out_data[0] !== 8'(8'h60 + i)) begin
        errors++;
        $display("FAIL s0_pass%0d: got %b/%0d/%h want 1/1/%h",
                 i, in_ready[0], occ[0], out_data[0], 8'(8'h60 + i));
      end
      adv();
    end
    in_valid[0] = 0;
    adv();
    idle();
  endtask

  task automatic test_reset_mid();
    in_valid[1] = 1; in_data[1] = 8'h70; adv();
    in_data[1] = 8'h71; adv();
    rst[1] = 1; flush[1] = 1; in_data[1] = 8'h72;
    adv();
    checks++;
    if (occ[1] !== 2'd0 || out_valid[1] !== 1'b0
        || out_data[1] !== 8'hA5 || in_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_state: got %0d/%b/%h/%b want 0/0/a5/1",
               occ[1], out_valid[1], out_data[1], in_ready[1]);
    end
    rst[1] = 0; flush[1] = 0; in_data[1] = 8'h55;
    adv();
    in_valid[1] = 0;
    #1;
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h55
        || occ[1] !== 2'd1) begin
      errors++;
      $display("FAIL rmid_first: got %b/%h/%0d want 1/55/1",
               out_valid[1], out_data[1], occ[1]);
    end
    out_ready[1] = 1;
    adv();
    idle();
  endtask

  task automatic test_random();
    logic hold[2];
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          in_valid[k] = ($urandom_range(0, 9) < 7);
          in_data[k]  = 8'($urandom);
        end
        out_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]     = ($urandom_range(0, 24) == 0);
        rst[k]       = ($urandom_range(0, 59) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (occ[k] !== 2'(msize(k))
            || out_valid[k] !== (msize(k) > 0)
            || out_data[k] !== mhead(k)
            || in_ready[k] !== mready(k)) begin
          errors++;
          $display("FAIL rnd%0d c%0d: got %0d/%b/%h/%b want %0d/%b/%h/%b",
                   k, c, occ[k], out_valid[k], out_data[k], in_ready[k],
                   msize(k), (msize(k) > 0), mhead(k), mready(k));
        end
        hold[k] = in_valid[k] && !mready(k) && !flush[k] && !rst[k];
      end
      adv();
    end
    idle();
  endtask

  initial begin
    in_data[0] = 8'h00;
    in_data[1] = 8'h00;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_skid0_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
